// File: rtl/alien_sched_pkg.sv
// Shared definitions for the alien scan scheduler: FSM encoding, grant ids
// and default geometry of the alien array.
package alien_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } schedState_t;

  localparam logic GNT_MARCH = 1'b0;
  localparam logic GNT_HIT   = 1'b1;

  localparam int DEFAULT_ALIEN_COUNT = 16;
  localparam int DEFAULT_INDEX_WIDTH = 5;

endpackage

// File: rtl/alien_index_counter.sv
// Alien index counter: clears to zero, advances by one when enabled, and
// saturates at the last alien so the index can never run past the array.
module alien_index_counter
  import alien_sched_pkg::*;
#(
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int ALIEN_COUNT = DEFAULT_ALIEN_COUNT
) (
  input  logic                   SC_IDXCNT_CLOCK_50,
  input  logic                   SC_IDXCNT_RESET_InHigh,
  input  logic                   SC_IDXCNT_clear_InHigh,
  input  logic                   SC_IDXCNT_enable_InHigh,
  output logic [INDEX_WIDTH-1:0] SC_IDXCNT_count_OutBus,
  output logic                   SC_IDXCNT_terminal_OutHigh
);

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(ALIEN_COUNT - 1);
  localparam logic [INDEX_WIDTH-1:0] ONE        = INDEX_WIDTH'(1);

  logic [INDEX_WIDTH-1:0] count_r;
  logic                   terminal_s;

  assign terminal_s = (count_r == LAST_INDEX);

  // Index register: clear has priority over enable, no increment past the last alien
  always_ff @(posedge SC_IDXCNT_CLOCK_50) begin
    if (SC_IDXCNT_RESET_InHigh) begin
      count_r <= {INDEX_WIDTH{1'b0}};
    end else if (SC_IDXCNT_clear_InHigh) begin
      count_r <= {INDEX_WIDTH{1'b0}};
    end else if (SC_IDXCNT_enable_InHigh && !terminal_s) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign SC_IDXCNT_count_OutBus     = count_r;
  assign SC_IDXCNT_terminal_OutHigh = terminal_s;

endmodule

// File: rtl/alien_scan_scheduler.sv
// Shares one alien-array scan between the march updater and the hit checker
// with round-robin arbitration; one full 0..ALIEN_COUNT-1 walk per grant.
module alien_scan_scheduler
  import alien_sched_pkg::*;
#(
  parameter int ALIEN_COUNT = DEFAULT_ALIEN_COUNT,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
  input  logic                   SC_ALIENSCHED_CLOCK_50,
  input  logic                   SC_ALIENSCHED_RESET_InHigh,
  input  logic                   SC_ALIENSCHED_reqMarch_InHigh,
  input  logic                   SC_ALIENSCHED_reqHit_InHigh,
  input  logic                   SC_ALIENSCHED_hold_InHigh,
  input  logic                   SC_ALIENSCHED_abort_InHigh,
  output logic [INDEX_WIDTH-1:0] SC_ALIENSCHED_index_OutBus,
  output logic                   SC_ALIENSCHED_valid_OutHigh,
  output logic                   SC_ALIENSCHED_grantMarch_OutHigh,
  output logic                   SC_ALIENSCHED_grantHit_OutHigh,
  output logic                   SC_ALIENSCHED_done_OutHigh,
  output logic                   SC_ALIENSCHED_aborted_OutHigh
);

  schedState_t state_r, nextState_s;
  logic        owner_r, nextOwner_s;
  logic        rrPtr_r, nextRrPtr_s;
  logic        scanning_r, grantMarch_r, grantHit_r, done_r, aborted_r;
  logic        cntClear_s, cntEnable_s, lastIndex_s;

  alien_index_counter #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .ALIEN_COUNT (ALIEN_COUNT)
  ) u_indexCounter (
    .SC_IDXCNT_CLOCK_50         (SC_ALIENSCHED_CLOCK_50),
    .SC_IDXCNT_RESET_InHigh     (SC_ALIENSCHED_RESET_InHigh),
    .SC_IDXCNT_clear_InHigh     (cntClear_s),
    .SC_IDXCNT_enable_InHigh    (cntEnable_s),
    .SC_IDXCNT_count_OutBus     (SC_ALIENSCHED_index_OutBus),
    .SC_IDXCNT_terminal_OutHigh (lastIndex_s)
  );

  // Next-state, arbitration and counter control
  always_comb begin
    nextState_s = state_r;
    nextOwner_s = owner_r;
    nextRrPtr_s = rrPtr_r;
    cntClear_s  = 1'b0;
    cntEnable_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cntClear_s = 1'b1;
        if (SC_ALIENSCHED_reqMarch_InHigh && SC_ALIENSCHED_reqHit_InHigh) begin
          nextOwner_s = rrPtr_r;
          nextState_s = ST_SCAN;
        end else if (SC_ALIENSCHED_reqMarch_InHigh) begin
          nextOwner_s = GNT_MARCH;
          nextState_s = ST_SCAN;
        end else if (SC_ALIENSCHED_reqHit_InHigh) begin
          nextOwner_s = GNT_HIT;
          nextState_s = ST_SCAN;
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        // abort beats both hold and completion of the last index
        if (SC_ALIENSCHED_abort_InHigh) begin
          nextState_s = ST_ABORT;
        end else if (SC_ALIENSCHED_hold_InHigh) begin
          nextState_s = ST_SCAN;
        end else if (lastIndex_s) begin
          nextState_s = ST_DONE;
        end else begin
          cntEnable_s = 1'b1;
        end
      end
      ST_DONE, ST_ABORT: begin
        cntClear_s  = 1'b1;
        nextRrPtr_s = ~owner_r;
        nextState_s = ST_IDLE;
      end
      default: begin
        cntClear_s  = 1'b1;
        nextState_s = ST_IDLE;
      end
    endcase
  end

  // State, round-robin pointer and registered status outputs
  always_ff @(posedge SC_ALIENSCHED_CLOCK_50) begin
    if (SC_ALIENSCHED_RESET_InHigh) begin
      state_r      <= ST_IDLE;
      owner_r      <= GNT_MARCH;
      rrPtr_r      <= GNT_MARCH;
      scanning_r   <= 1'b0;
      grantMarch_r <= 1'b0;
      grantHit_r   <= 1'b0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
    end else begin
      state_r      <= nextState_s;
      owner_r      <= nextOwner_s;
      rrPtr_r      <= nextRrPtr_s;
      scanning_r   <= (nextState_s == ST_SCAN);
      grantMarch_r <= (nextState_s != ST_IDLE) && (nextOwner_s == GNT_MARCH);
      grantHit_r   <= (nextState_s != ST_IDLE) && (nextOwner_s == GNT_HIT);
      done_r       <= (nextState_s == ST_DONE);
      aborted_r    <= (nextState_s == ST_ABORT);
    end
  end

  // hold retracts valid in the same cycle so the RAM never sees a frozen index as new
  assign SC_ALIENSCHED_valid_OutHigh      = scanning_r & ~SC_ALIENSCHED_hold_InHigh;
  assign SC_ALIENSCHED_grantMarch_OutHigh = grantMarch_r;
  assign SC_ALIENSCHED_grantHit_OutHigh   = grantHit_r;
  assign SC_ALIENSCHED_done_OutHigh       = done_r;
  assign SC_ALIENSCHED_aborted_OutHigh    = aborted_r;

endmodule
